ram_prefetch_ctrl: RTL and testbench

RAM_PREFETCH_CTRL -- requirements
Module: ram_prefetch_ctrl

---
 rtl/ram_prefetch_ctrl_if.sv | 42 ++++
 rtl/ram_prefetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_ram_prefetch_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_prefetch_ctrl_if.sv
// ram_prefetch_ctrl_if
// Bundles the control, status and strobe signals between the FIFO control
// logic / buffer consumer (master side) and the RAM prefetch controller
// (slave side). Clock and reset are kept as plain module ports.
//
// Signals:
//   enable        master->slave  prefetch permission (RAM-read phase)
//   ram_empty     master->slave  RAM storage holds no readable word
//   buf_read      master->slave  consumer pops one buffered word this cycle
//   flush         master->slave  synchronous abort of buffer and in-flight reads
//   ram_read      slave->master  RAM read strobe, one word per asserted cycle
//   buf_write     slave->master  RAM data valid at the buffer input this cycle
//   credit        slave->master  free slots not reserved by in-flight reads
//   inflight      slave->master  reads issued but not yet returned
//   occupancy     slave->master  words held in the buffer
//   busy          slave->master  controller is fetching or draining
//   err_underflow slave->master  one-cycle pulse after an illegal buf_read
interface ram_prefetch_ctrl_if #(
   parameter int CNT_WIDTH = 3
);
   logic                 enable;
   logic                 ram_empty;
   logic                 buf_read;
   logic                 flush;
   logic                 ram_read;
   logic                 buf_write;
   logic [CNT_WIDTH-1:0] credit;
   logic [CNT_WIDTH-1:0] inflight;
   logic [CNT_WIDTH-1:0] occupancy;
   logic                 busy;
   logic                 err_underflow;

   modport master (
      output enable, ram_empty, buf_read, flush,
      input  ram_read, buf_write, credit, inflight, occupancy, busy, err_underflow
   );

   modport slave (
      input  enable, ram_empty, buf_read, flush,
      output ram_read, buf_write, credit, inflight, occupancy, busy, err_underflow
   );
endinterface

// File: rtl/ram_prefetch_ctrl.sv
// ram_prefetch_ctrl
// Issues RAM reads ahead of the consumer into a small output buffer. Every
// read reserves one buffer slot at issue time, so the buffer can never be
// overrun: credit = BUF_DEPTH - occupancy - inflight, and a read is only
// issued while credit is non-zero. Read data returns a fixed LATENCY cycles
// after the strobe, tracked by a shift register of valid bits.
//
// Parameters:
//   LATENCY    RAM read latency in cycles (1..8)
//   BUF_DEPTH  output buffer entries (2..16)
//   CNT_WIDTH  width of the credit/inflight/occupancy counts
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    slave side of ram_prefetch_ctrl_if (controls in, strobes/counts out)
module ram_prefetch_ctrl #(
   parameter int LATENCY   = 3,
   parameter int BUF_DEPTH = 4,
   parameter int CNT_WIDTH = $clog2(BUF_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   ram_prefetch_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(BUF_DEPTH);

   logic [1:0]           state_reg;
   logic [1:0]           state_next;
   logic [LATENCY-1:0]   pipe_reg;
   logic [LATENCY-1:0]   pipe_next;
   logic [CNT_WIDTH-1:0] inflight_reg;
   logic [CNT_WIDTH-1:0] inflight_next;
   logic [CNT_WIDTH-1:0] occupancy_reg;
   logic [CNT_WIDTH-1:0] occupancy_next;
   logic                 err_reg;
   logic                 err_next;

   logic [CNT_WIDTH-1:0] credit_c;
   logic                 ram_read_c;
   logic                 buf_write_c;
   logic                 rd_legal_c;
   logic [CNT_WIDTH:0]   booked_c;

   // Slots already promised: words held plus words still on their way.
   assign credit_c = DEPTH_C - occupancy_reg - inflight_reg;

   assign ram_read_c = (state_reg == ST_FETCH) & bus.enable & ~bus.ram_empty &
                       (credit_c != '0) & ~bus.flush;

   // Data returning during a flush belongs to a discarded read; suppress it.
   assign buf_write_c = pipe_reg[LATENCY-1] & ~bus.flush;

   // Legality is judged on the registered occupancy, so a word arriving in
   // the same cycle cannot be popped yet.
   assign rd_legal_c = bus.buf_read & (occupancy_reg != '0);

   // ------------------------------------------------------------------
   // Read-return pipeline: stage 0 takes the strobe, last stage is the
   // buffer write. A flush empties every stage at once.
   // ------------------------------------------------------------------
   assign pipe_next[0] = ram_read_c & ~bus.flush;

   generate
      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_pipe
         assign pipe_next[gi] = pipe_reg[gi-1] & ~bus.flush;
      end
   endgenerate

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (bus.flush) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.enable) state_next = ST_FETCH;
            end
            ST_FETCH: begin
               if (!bus.enable) begin
                  state_next = (inflight_reg != '0) ? ST_DRAIN : ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (bus.enable) begin
                  state_next = ST_FETCH;
               end else if (inflight_reg == '0) begin
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Counters and underflow flag
   // ------------------------------------------------------------------
   always_comb begin
      inflight_next  = inflight_reg;
      occupancy_next = occupancy_reg;
      err_next       = bus.buf_read & (occupancy_reg == '0);
      if (bus.flush) begin
         inflight_next  = '0;
         occupancy_next = '0;
      end else begin
         inflight_next  = inflight_reg + CNT_WIDTH'(ram_read_c) - CNT_WIDTH'(buf_write_c);
         occupancy_next = occupancy_reg + CNT_WIDTH'(buf_write_c) - CNT_WIDTH'(rd_legal_c);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         pipe_reg      <= '0;
         inflight_reg  <= '0;
         occupancy_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pipe_reg      <= pipe_next;
         inflight_reg  <= inflight_next;
         occupancy_reg <= occupancy_next;
         err_reg       <= err_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.ram_read      = ram_read_c;
   assign bus.buf_write     = buf_write_c;
   assign bus.credit        = credit_c;
   assign bus.inflight      = inflight_reg;
   assign bus.occupancy     = occupancy_reg;
   assign bus.busy          = (state_reg == ST_FETCH) | (state_reg == ST_DRAIN);
   assign bus.err_underflow = err_reg;

   // Credit gating makes overbooking impossible; catch it if logic changes.
   assign booked_c = {1'b0, occupancy_reg} + {1'b0, inflight_reg};

   ap_no_overbook : assert property (@(posedge clk) disable iff (!reset)
      booked_c <= (CNT_WIDTH+1)'(BUF_DEPTH));

endmodule

// File: tb/tb_ram_prefetch_ctrl.sv
// tb_ram_prefetch_ctrl
// Self-checking bench for ram_prefetch_ctrl (LATENCY=3, BUF_DEPTH=4).
// A cycle table of {inputs, expected outputs} covers fill, credit
// exhaustion, underflow, flush, ram_empty and drain. Hand-written
// sequences cover streaming with a consumer, drain timing and async reset.
// A scoreboard queue records the cycle each read must return in and checks
// every buf_write against it.
module tb_ram_prefetch_ctrl;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk;
   logic reset;

   ram_prefetch_ctrl_if #(.CNT_WIDTH(CW)) bus ();

   ram_prefetch_ctrl #(.LATENCY(LAT), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          en, emp, rd, fl;
      logic          rr, bw;
      logic [CW-1:0] cr, inf, occ;
      logic          busy, err;
   } vec_t;

   vec_t vecs[$];
   int   sb_q[$];
   int   cyc;
   int   checks;
   int   failures;
   int   n_reads;
   int   n_writes;

   function automatic vec_t mk(input logic en, emp, rd, fl, rr, bw,
                               input int cr, inf, occ, input logic busy, err);
      vec_t v;
      v.en = en; v.emp = emp; v.rd = rd; v.fl = fl;
      v.rr = rr; v.bw = bw;
      v.cr = CW'(cr); v.inf = CW'(inf); v.occ = CW'(occ);
      v.busy = busy; v.err = err;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic drive(input logic en, emp, rd, fl);
      bus.enable    = en;
      bus.ram_empty = emp;
      bus.buf_read  = rd;
      bus.flush     = fl;
   endtask

   // Scoreboard update, called once per cycle at the sampling point.
   task automatic sb_sample();
      if (bus.buf_write) begin
         n_writes++;
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_return cycle=%0d actual=unexpected_write required=none", cyc);
         end else begin
            if (sb_q[0] != cyc) begin
               failures++;
               $display("FAIL sb_return actual_cycle=%0d required_cycle=%0d", cyc, sb_q[0]);
            end
            void'(sb_q.pop_front());
         end
      end
      if (bus.flush) sb_q.delete();
      if (bus.ram_read) begin
         n_reads++;
         sb_q.push_back(cyc + LAT);
      end
      cyc++;
   endtask

   task automatic samp();
      @(negedge clk);
      sb_sample();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ram_read"},  int'(bus.ram_read), 0);
      check({tag, "_buf_write"}, int'(bus.buf_write), 0);
      check({tag, "_busy"},      int'(bus.busy), 0);
      check({tag, "_err"},       int'(bus.err_underflow), 0);
      check({tag, "_credit"},    int'(bus.credit), DEPTH);
      check({tag, "_inflight"},  int'(bus.inflight), 0);
      check({tag, "_occupancy"}, int'(bus.occupancy), 0);
   endtask

   initial begin
      int  legal;
      int  busy_cycles;
      int  bw_count;
      bit  done;
      logic prev_illegal;

      checks = 0; failures = 0; cyc = 0; n_reads = 0; n_writes = 0;
      drive(0, 0, 0, 0);
      reset = 1'b1;
      #1 reset = 1'b0;
      #2 check_reset_vals("reset_initial");

      // en, emp, rd, fl | rr, bw, credit, inflight, occupancy, busy, err
      vecs.push_back(mk(0,0,0,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0, 1,0, 4,0,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 1,0, 3,1,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 1,0, 2,2,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 1,1, 1,3,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 0,1, 0,3,1, 1,0));
      vecs.push_back(mk(1,0,0,0, 0,1, 0,2,2, 1,0));
      vecs.push_back(mk(1,0,0,0, 0,1, 0,1,3, 1,0));
      vecs.push_back(mk(1,0,0,0, 0,0, 0,0,4, 1,0));
      vecs.push_back(mk(0,0,1,0, 0,0, 0,0,4, 1,0));
      vecs.push_back(mk(0,0,1,0, 0,0, 1,0,3, 0,0));
      vecs.push_back(mk(0,0,1,0, 0,0, 2,0,2, 0,0));
      vecs.push_back(mk(0,0,1,0, 0,0, 3,0,1, 0,0));
      vecs.push_back(mk(0,0,1,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 4,0,0, 0,1));
      vecs.push_back(mk(0,0,0,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0, 1,0, 4,0,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 1,0, 3,1,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 1,0, 2,2,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 1,1, 1,3,0, 1,0));
      vecs.push_back(mk(1,0,0,1, 0,0, 0,3,1, 1,0));
      vecs.push_back(mk(1,0,0,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 4,0,0, 1,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(1,1,0,0, 0,0, 4,0,0, 0,0));
      vecs.push_back(mk(1,1,0,0, 0,0, 4,0,0, 1,0));
      vecs.push_back(mk(1,0,0,0, 1,0, 4,0,0, 1,0));
      vecs.push_back(mk(1,1,0,0, 0,0, 3,1,0, 1,0));
      vecs.push_back(mk(0,1,0,0, 0,0, 3,1,0, 1,0));
      vecs.push_back(mk(0,0,0,0, 0,1, 3,1,0, 1,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 3,0,1, 1,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 3,0,1, 0,0));
      vecs.push_back(mk(0,0,1,0, 0,0, 3,0,1, 0,0));
      vecs.push_back(mk(0,0,0,0, 0,0, 4,0,0, 0,0));

      tick();
      tick();
      reset = 1'b1;

      // ---------------- table-driven cycles ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].emp, vecs[i].rd, vecs[i].fl);
         samp();
         checks++;
         if (bus.ram_read !== vecs[i].rr || bus.buf_write !== vecs[i].bw ||
             bus.credit !== vecs[i].cr || bus.inflight !== vecs[i].inf ||
             bus.occupancy !== vecs[i].occ || bus.busy !== vecs[i].busy ||
             bus.err_underflow !== vecs[i].err) begin
            failures++;
            $display("FAIL vec[%0d] actual rr=%b bw=%b cr=%0d inf=%0d occ=%0d busy=%b err=%b required rr=%b bw=%b cr=%0d inf=%0d occ=%0d busy=%b err=%b",
                     i, bus.ram_read, bus.buf_write, bus.credit, bus.inflight,
                     bus.occupancy, bus.busy, bus.err_underflow,
                     vecs[i].rr, vecs[i].bw, vecs[i].cr, vecs[i].inf,
                     vecs[i].occ, vecs[i].busy, vecs[i].err);
         end else begin
            $display("vec[%0d] ok rr=%b bw=%b cr=%0d inf=%0d occ=%0d busy=%b err=%b",
                     i, bus.ram_read, bus.buf_write, bus.credit, bus.inflight,
                     bus.occupancy, bus.busy, bus.err_underflow);
         end
         tick();
      end

      // ---------------- streaming with a consumer popping every cycle ----------------
      n_reads = 0; n_writes = 0; legal = 0; prev_illegal = 1'b0;
      drive(1, 0, 1, 0);
      for (int i = 0; i < 24; i++) begin
         samp();
         check("stream_credit_sum", int'(bus.credit),
               DEPTH - int'(bus.occupancy) - int'(bus.inflight));
         check("stream_err_follows", int'(bus.err_underflow), int'(prev_illegal));
         prev_illegal = (bus.occupancy == '0);
         if (bus.occupancy != '0) legal++;
         tick();
      end
      $display("stream reads=%0d writes=%0d legal_pops=%0d", n_reads, n_writes, legal);
      drive(0, 0, 0, 0);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         samp();
         if (!bus.busy && bus.inflight == '0) done = 1;
         tick();
      end
      check("stream_drain_timeout", int'(done), 1);
      check("stream_reads_returned", n_writes, n_reads);
      check("stream_occupancy", int'(bus.occupancy), n_writes - legal);
      for (int i = 0; i < 12; i++) begin
         bus.buf_read = (bus.occupancy != '0);
         if (!bus.buf_read) break;
         samp();
         tick();
      end
      bus.buf_read = 1'b0;
      check("stream_empty_after_pop", int'(bus.occupancy), 0);

      // ---------------- enable drops with two reads in flight ----------------
      drive(1, 0, 0, 0);
      samp(); tick();
      samp(); check("drain_rr_c1", int'(bus.ram_read), 1); tick();
      samp(); check("drain_rr_c2", int'(bus.ram_read), 1); tick();
      drive(0, 0, 0, 0);
      samp();
      check("drain_inflight", int'(bus.inflight), 2);
      busy_cycles = 0; bw_count = 0; done = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) samp();
         if (bus.buf_write) bw_count++;
         if (!bus.busy) begin
            done = 1;
            tick();
            break;
         end
         busy_cycles++;
         tick();
      end
      $display("drain busy_cycles=%0d buf_writes=%0d", busy_cycles, bw_count);
      check("drain_idle_reached", int'(done), 1);
      check("drain_busy_cycles", busy_cycles, 4);
      check("drain_buf_writes", bw_count, 2);
      check("drain_occupancy", int'(bus.occupancy), 2);

      // ---------------- asynchronous reset mid-FETCH ----------------
      drive(1, 0, 0, 0);
      samp(); tick();
      samp(); tick();
      samp();
      check("pre_reset_busy", int'(bus.busy), 1);
      #2 reset = 1'b0;
      sb_q.delete();
      #1 check_reset_vals("async_reset");
      tick();
      check_reset_vals("reset_held");
      #2 reset = 1'b1;
      samp();
      check("release_first_cycle_rr", int'(bus.ram_read), 0);
      tick();
      samp();
      check("release_second_cycle_rr", int'(bus.ram_read), 1);
      tick();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         samp();
         tick();
      end
      check("sb_all_returned", sb_q.size(), 0);
      check("final_busy", int'(bus.busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
